// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, one transaction at a time.
// Optional fetch-starvation guard enabled by defining ARB_FAIRNESS_EN.
module unified_mem_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_DATA_WINS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ready,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_ready,
    output logic            dm_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t state;
    owner_t owner;
    logic   killQ;
    logic   grantDm, grantIf;

`ifdef ARB_FAIRNESS_EN
    localparam int CW = $clog2(MAX_DATA_WINS + 1);
    logic [CW-1:0] winCnt;
    logic          fairIf;

    // Once data has won MAX_DATA_WINS times in a row against a waiting fetch, fetch goes next.
    assign fairIf  = if_req && !if_kill && (winCnt >= CW'(MAX_DATA_WINS));
    assign grantDm = dm_req && !fairIf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            winCnt <= '0;
        else if (!if_req)
            winCnt <= '0;
        else if (state == IDLE && grantIf)
            winCnt <= '0;
        else if (state == IDLE && grantDm && winCnt != CW'(MAX_DATA_WINS))
            winCnt <= winCnt + 1'b1;
    end
`else
    assign grantDm = dm_req;
`endif

    assign grantIf = !grantDm && if_req && !if_kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            killQ     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    killQ <= 1'b0;
                    if (grantDm) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_be    <= dm_be;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        owner     <= OWN_DM;
                        state     <= REQ;
                    end else if (grantIf) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_be    <= '1;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        owner     <= OWN_IF;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (if_kill && owner == OWN_IF) killQ <= 1'b1;
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // A killed fetch still drains on the memory side; only its ready is dropped.
                    if (if_kill && owner == OWN_IF) killQ <= 1'b1;
                    if (mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_ready = (state == WAIT) && mem_rvalid && (owner == OWN_IF) && !killQ && !if_kill;
    assign dm_ready = (state == WAIT) && mem_rvalid && (owner == OWN_DM);
    assign if_rdata = if_ready ? mem_rdata : '0;
    assign dm_rdata = dm_ready ? mem_rdata : '0;
    assign if_stall = if_req && !if_ready;
    assign dm_stall = dm_req && !dm_ready;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: memory responder model plus ordered scoreboard of ready pulses.
module tb_unified_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_kill, if_ready, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_ready, dm_stall;
    logic [3:0]    dm_be;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_DATA_WINS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        isDm;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ifCyc = 0;
    int   dmCyc = 0;
    int   gntDelay = 0;
    int   rvDelay = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memData(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h12345678;
    endfunction

    function automatic void pushExp(input logic isDm, input logic [31:0] data);
        exp_t e;
        e.isDm = isDm;
        e.data = data;
        expQ.push_back(e);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: grant after gntDelay cycles of mem_req, respond rvDelay cycles after the grant edge.
    initial begin
        int          gntCnt = 0;
        int          rvCnt = 0;
        logic        rvPend = 1'b0;
        logic        gWe = 1'b0;
        logic [31:0] gAddr = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata = '0;
            if (mem_gnt) begin
                mem_gnt = 1'b0;
                rvPend = 1'b1;
                rvCnt = rvDelay;
            end else if (mem_req) begin
                if (gntCnt >= gntDelay) begin
                    mem_gnt = 1'b1;
                    gntCnt = 0;
                    gAddr = mem_addr;
                    gWe = mem_we;
                end else gntCnt++;
            end
            if (rvPend) begin
                if (rvCnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = gWe ? 32'h0 : memData(gAddr);
                    rvPend = 1'b0;
                end else rvCnt--;
            end
        end
    end

    // Scoreboard: every ready pulse must match the oldest expected completion.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (if_ready || dm_ready) begin
            chk("one_ready", 64'(if_ready && dm_ready), 64'd0);
            chk("sb_pending", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("owner", 64'(dm_ready), 64'(e.isDm));
                chk("rdata", 64'(dm_ready ? dm_rdata : if_rdata), 64'(e.data));
            end
            if (if_ready) ifCyc = cyc;
            if (dm_ready) dmCyc = cyc;
        end else if (mem_rvalid) begin
            chk("if_rdata_quiet", 64'(if_rdata), 64'd0);
            chk("dm_rdata_quiet", 64'(dm_rdata), 64'd0);
        end
    end

    task automatic doFetch(input logic [31:0] a, input int bound, output int lat);
        @(posedge clk);
        #1;
        if_req = 1'b1;
        if_addr = a;
        lat = 0;
        repeat (bound) begin
            @(negedge clk);
            if (if_ready) break;
            lat++;
        end
        chk("if_done", 64'(if_ready), 64'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic doDm(input logic we, input logic [3:0] be, input logic [31:0] base,
                        input logic [31:0] wd, input int n, input int bound);
        @(posedge clk);
        #1;
        dm_req = 1'b1;
        dm_we = we;
        dm_be = be;
        dm_wdata = wd;
        for (int i = 0; i < n; i++) begin
            dm_addr = base + 32'(4 * i);
            repeat (bound) begin
                @(negedge clk);
                if (dm_ready) break;
            end
            chk("dm_done", 64'(dm_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        dm_req = 1'b0;
    endtask

    task automatic chkOutputsZero(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_mem_be"}, 64'(mem_be), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_if_ready"}, 64'(if_ready), 64'd0);
        chk({tag, "_dm_ready"}, 64'(dm_ready), 64'd0);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        chk({tag, "_dm_rdata"}, 64'(dm_rdata), 64'd0);
        chk({tag, "_stalls"}, 64'({if_stall, dm_stall}), 64'd0);
    endtask

    initial begin
        int lat;
        int reqCyc;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chkOutputsZero("rst");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // zero-wait fetch: ready two cycles after request
        pushExp(1'b0, 32'h00500093);
        doFetch(32'h10, 20, lat);
        chk("if_latency", 64'(lat), 64'd2);

        // simultaneous requests: load first, fetch three cycles later
        pushExp(1'b1, memData(32'h100));
        pushExp(1'b0, 32'h00500093);
        fork
            doFetch(32'h10, 20, lat);
            doDm(1'b0, 4'hF, 32'h100, 32'h0, 1, 20);
        join
        chk("if_after_dm", 64'(ifCyc - dmCyc), 64'd3);

        // store with grant delayed 3 cycles: request fields held throughout
        gntDelay = 3;
        pushExp(1'b1, 32'h0);
        reqCyc = 0;
        fork
            doDm(1'b1, 4'b0010, 32'h204, 32'h0000AB00, 1, 20);
            repeat (12) begin
                @(negedge clk);
                if (mem_req) begin
                    reqCyc++;
                    chk("st_we", 64'(mem_we), 64'd1);
                    chk("st_be", 64'(mem_be), 64'h2);
                    chk("st_addr", 64'(mem_addr), 64'h204);
                    chk("st_wdata", 64'(mem_wdata), 64'h0000AB00);
                end
            end
        join
        chk("st_req_cycles", 64'(reqCyc), 64'd4);
        gntDelay = 0;

        // kill in IDLE blocks capture of the same-cycle fetch
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h60; if_kill = 1'b1;
        @(posedge clk);
        #1;
        if_req = 1'b0; if_kill = 1'b0;
        @(negedge clk);
        chk("kill_idle_noreq", 64'(mem_req), 64'd0);

        // kill while fetch is in WAIT: no ready, then a normal fetch
        rvDelay = 2;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        chk("if_stall", 64'(if_stall), 64'd1);
        repeat (10) begin
            @(negedge clk);
            if (mem_gnt) break;
        end
        chk("kill_gnt", 64'(mem_gnt), 64'd1);
        @(posedge clk);
        #1;
        if_kill = 1'b1; if_req = 1'b0;
        @(posedge clk);
        #1;
        if_kill = 1'b0;
        repeat (6) @(posedge clk);
        rvDelay = 0;
        pushExp(1'b0, memData(32'h40));
        doFetch(32'h40, 20, lat);

        // reset during WAIT: outputs drop at once, late response ignored
        rvDelay = 4;
        @(posedge clk);
        #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h300;
        repeat (10) begin
            @(negedge clk);
            if (mem_gnt) break;
        end
        chk("rst_gnt", 64'(mem_gnt), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        dm_req = 1'b0;
        #1;
        chkOutputsZero("rst_wait");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_idle_req", 64'(mem_req), 64'd0);
        rvDelay = 0;
        pushExp(1'b1, memData(32'h304));
        doDm(1'b0, 4'hF, 32'h304, 32'h0, 1, 20);

        // fetch waiting against a continuous stream of loads
`ifdef ARB_FAIRNESS_EN
        for (int i = 0; i < 4; i++) pushExp(1'b1, memData(32'h400 + 32'(4 * i)));
        pushExp(1'b0, memData(32'h500));
        pushExp(1'b1, memData(32'h410));
`else
        for (int i = 0; i < 5; i++) pushExp(1'b1, memData(32'h400 + 32'(4 * i)));
        pushExp(1'b0, memData(32'h500));
`endif
        fork
            doFetch(32'h500, 60, lat);
            doDm(1'b0, 4'hF, 32'h400, 32'h0, 5, 20);
        join
        repeat (4) @(posedge clk);
        chk("sb_drained", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
